io_port_bank: RTL and testbench

//  Parametrised memory-mapped I/O port bank replacing fixed 16-in/16-out port wiring inside memory.

---
 rtl/io_port_bank_pkg.sv | 38 +++
 rtl/io_port_bank_sync_edge.sv | 40 ++++
 rtl/io_port_bank.sv | 154 +++++++++++++++
 tb/tb_io_port_bank.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/io_port_bank_pkg.sv
// Shared definitions for the memory-mapped I/O port bank.
// Holds the default address map, the status-register count calculation,
// the address-region check and the decoded region type. The memory block
// imports this too, so the RAM decode can steer clear of the bank.
package io_port_bank_pkg;

  // Default bus geometry and address map
  localparam int          DEF_DATA_W    = 8;
  localparam int          DEF_ADDR_W    = 8;
  localparam int          DEF_NUM_PORTS = 16;
  localparam int unsigned DEF_OUT_BASE  = 32'h00E0;
  localparam int unsigned DEF_IN_BASE   = 32'h00F0;
  localparam int unsigned DEF_CHG_BASE  = 32'h00D0;
  localparam int unsigned DEF_MASK_BASE = 32'h00D8;

  // Which register region the current bus address falls into
  typedef enum logic [2:0] {
    REG_NONE,
    REG_OUT,
    REG_IN,
    REG_CHG,
    REG_MASK
  } region_e;

  // Number of DATA_W-wide registers needed to hold one flag bit per port
  function automatic int nstat_calc(input int num_ports, input int data_w);
    return (num_ports + data_w - 1) / data_w;
  endfunction

  // True when addr lies in [base, base+size). Arithmetic is done in 32 bits
  // so a region ending exactly at the top of the address space still works.
  function automatic logic in_region(input int unsigned addr,
                                     input int unsigned base,
                                     input int unsigned size);
    return (addr >= base) && (addr < base + size);
  endfunction

endpackage

// File: rtl/io_port_bank_sync_edge.sv
// Input synchroniser and change detector for one port.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   armed      : change detection enabled (after the post-reset settling time)
//   din        : asynchronous port input
//   sync       : synchronised value (second flop)
//   evt        : one-cycle pulse while the synchronised value differs from
//                the previous cycle's, gated by armed
module io_sync_edge #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              armed,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sync,
  output logic              evt
);

  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] prev;

  // Two-flop synchroniser followed by a one-cycle history register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign evt  = (s2 != prev) && armed;

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank that sits beside RAM on the CPU bus.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   address    : CPU bus address
//   write      : CPU write strobe
//   data_in    : CPU write data
//   data_out   : registered read data, 0 when the previous address missed
//   hit        : registered, previous address decoded into this bank
//   port_in    : asynchronous inputs, port k at [k*DATA_W +: DATA_W]
//   port_out   : output port registers, same packing
//   irq        : registered OR of pending change flags under the mask
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned OUT_BASE  = DEF_OUT_BASE,
  parameter int unsigned IN_BASE   = DEF_IN_BASE,
  parameter int unsigned CHG_BASE  = DEF_CHG_BASE,
  parameter int unsigned MASK_BASE = DEF_MASK_BASE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        write,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W-1:0]           data_out,
  output logic                        hit,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  output logic                        irq
);

  localparam int NSTAT  = nstat_calc(NUM_PORTS, DATA_W);
  localparam int FLAG_W = NSTAT * DATA_W;

  logic [NUM_PORTS*DATA_W-1:0] sync_bus;
  logic [NUM_PORTS-1:0]        evt;
  logic [FLAG_W-1:0]           valid;
  logic [FLAG_W-1:0]           evt_pad;
  logic [FLAG_W-1:0]           clr;
  logic [FLAG_W-1:0]           chg;
  logic [FLAG_W-1:0]           chg_next;
  logic [FLAG_W-1:0]           mask;
  logic [1:0]                  arm_cnt;
  logic                        armed;
  int unsigned                 addr_u;
  int unsigned                 idx;
  region_e                     region;
  logic [DATA_W-1:0]           rd_data;
  logic                        rd_hit;

  assign addr_u = 32'(address);
  assign armed  = (arm_cnt == 2'd3);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    io_sync_edge #(.DATA_W(DATA_W)) u_sync (
      .clk   (clk),
      .reset (reset),
      .armed (armed),
      .din   (port_in[k*DATA_W +: DATA_W]),
      .sync  (sync_bus[k*DATA_W +: DATA_W]),
      .evt   (evt[k])
    );
  end

  // Flag registers are padded to whole bus words; padding bits never hold a 1
  for (genvar b = 0; b < FLAG_W; b++) begin : g_flag
    if (b < NUM_PORTS) begin : g_real
      assign valid[b]   = 1'b1;
      assign evt_pad[b] = evt[b];
    end else begin : g_pad
      assign valid[b]   = 1'b0;
      assign evt_pad[b] = 1'b0;
    end
  end

  // Address decode into a region and an offset within it
  always_comb begin
    region = REG_NONE;
    idx    = 0;
    if (in_region(addr_u, OUT_BASE, NUM_PORTS)) begin
      region = REG_OUT;
      idx    = addr_u - OUT_BASE;
    end else if (in_region(addr_u, IN_BASE, NUM_PORTS)) begin
      region = REG_IN;
      idx    = addr_u - IN_BASE;
    end else if (in_region(addr_u, CHG_BASE, NSTAT)) begin
      region = REG_CHG;
      idx    = addr_u - CHG_BASE;
    end else if (in_region(addr_u, MASK_BASE, NSTAT)) begin
      region = REG_MASK;
      idx    = addr_u - MASK_BASE;
    end
  end

  // Read mux works on current (pre-write) state, so a read that coincides
  // with a write to the same address returns the old value
  always_comb begin
    rd_data = '0;
    rd_hit  = (region != REG_NONE);
    case (region)
      REG_OUT:
        for (int k = 0; k < NUM_PORTS; k++)
          if (idx == k) rd_data = port_out[k*DATA_W +: DATA_W];
      REG_IN:
        for (int k = 0; k < NUM_PORTS; k++)
          if (idx == k) rd_data = sync_bus[k*DATA_W +: DATA_W];
      REG_CHG:
        for (int j = 0; j < NSTAT; j++)
          if (idx == j) rd_data = chg[j*DATA_W +: DATA_W];
      REG_MASK:
        for (int j = 0; j < NSTAT; j++)
          if (idx == j) rd_data = mask[j*DATA_W +: DATA_W];
      default: rd_data = '0;
    endcase
  end

  // Write-1-to-clear of change flags; a new event in the same cycle wins
  always_comb begin
    clr = '0;
    if (write && region == REG_CHG)
      for (int j = 0; j < NSTAT; j++)
        if (idx == j) clr[j*DATA_W +: DATA_W] = data_in;
    chg_next = (chg & ~(clr & valid)) | evt_pad;
  end

  // Register file, read pipeline, irq and post-reset arming counter
  always_ff @(posedge clk) begin
    if (reset) begin
      port_out <= '0;
      mask     <= '0;
      chg      <= '0;
      data_out <= '0;
      hit      <= 1'b0;
      irq      <= 1'b0;
      arm_cnt  <= 2'd0;
    end else begin
      if (write && region == REG_OUT)
        for (int k = 0; k < NUM_PORTS; k++)
          if (idx == k) port_out[k*DATA_W +: DATA_W] <= data_in;
      if (write && region == REG_MASK)
        for (int j = 0; j < NSTAT; j++)
          if (idx == j) mask[j*DATA_W +: DATA_W] <= data_in & valid[j*DATA_W +: DATA_W];
      chg      <= chg_next;
      data_out <= rd_data;
      hit      <= rd_hit;
      irq      <= |(chg & mask);
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed testbench for io_port_bank with the default 16-port map.
module tb_io_port_bank;

  localparam int DW = 8;
  localparam int NP = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        address;
  logic              write;
  logic [DW-1:0]     data_in;
  logic [DW-1:0]     data_out;
  logic              hit;
  logic [NP*DW-1:0]  port_in;
  logic [NP*DW-1:0]  port_out;
  logic              irq;

  int checks = 0;
  int errors = 0;
  logic [NP*DW-1:0] exp_port_out;

  io_port_bank #(.DATA_W(DW), .ADDR_W(8), .NUM_PORTS(NP)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out),
    .hit      (hit),
    .port_in  (port_in),
    .port_out (port_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Present one bus cycle, then sample just after the edge
  task automatic applyStimulus(input logic [7:0] a, input logic w, input logic [7:0] d);
    address = a;
    write   = w;
    data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  // Single comparison point for every check
  task automatic checkOutput(input string tag, input logic [NP*DW-1:0] act,
                             input logic [NP*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    address = 8'h10;
    write   = 1'b0;
    data_in = '0;
    port_in = {NP{8'hFF}};
    exp_port_out = '0;

    // Reset held two cycles with inputs high
    applyStimulus(8'h10, 1'b0, 8'h00);
    applyStimulus(8'h10, 1'b0, 8'h00);
    checkOutput("reset_port_out", port_out, '0);
    checkOutput("reset_irq", {127'd0, irq}, '0);
    checkOutput("reset_hit", {127'd0, hit}, '0);
    checkOutput("reset_data_out", {120'd0, data_out}, '0);

    reset = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'h10, 1'b0, 8'h00);
    applyStimulus(8'hD0, 1'b0, 8'h00);
    checkOutput("arm_chg0", {120'd0, data_out}, '0);
    applyStimulus(8'hD1, 1'b0, 8'h00);
    checkOutput("arm_chg1", {120'd0, data_out}, '0);
    checkOutput("arm_irq", {127'd0, irq}, '0);
    applyStimulus(8'hF0, 1'b0, 8'h00);
    checkOutput("in0_read", {120'd0, data_out}, 128'hFF);

    // Output port write, read-during-write, then read-back
    applyStimulus(8'hE3, 1'b1, 8'hA5);
    exp_port_out[3*DW +: DW] = 8'hA5;
    checkOutput("out3_write", port_out, exp_port_out);
    checkOutput("rdw_old_value", {120'd0, data_out}, '0);
    applyStimulus(8'hE3, 1'b0, 8'h00);
    checkOutput("out3_read", {120'd0, data_out}, 128'hA5);
    checkOutput("out3_hit", {127'd0, hit}, 128'd1);

    // Mask port 9 (reg 1 bit 1), then change port 9
    applyStimulus(8'hD9, 1'b1, 8'h02);
    port_in[9*DW +: DW] = 8'h3C;
    applyStimulus(8'hF9, 1'b0, 8'h00);
    applyStimulus(8'hF9, 1'b0, 8'h00);
    checkOutput("in9_before_sync", {120'd0, data_out}, 128'hFF);
    applyStimulus(8'hF9, 1'b0, 8'h00);
    checkOutput("in9_synced", {120'd0, data_out}, 128'h3C);
    checkOutput("irq_not_yet", {127'd0, irq}, '0);
    applyStimulus(8'hD1, 1'b0, 8'h00);
    checkOutput("chg1_set", {120'd0, data_out}, 128'h02);
    checkOutput("irq_set", {127'd0, irq}, 128'd1);

    // W1C coinciding with a fresh event on port 9: flag must survive
    port_in[9*DW +: DW] = 8'h00;
    applyStimulus(8'h10, 1'b0, 8'h00);
    applyStimulus(8'h10, 1'b0, 8'h00);
    applyStimulus(8'hD1, 1'b1, 8'h02);
    applyStimulus(8'hD1, 1'b0, 8'h00);
    checkOutput("w1c_set_wins", {120'd0, data_out}, 128'h02);
    applyStimulus(8'hD1, 1'b1, 8'h02);
    checkOutput("w1c_rdw_old", {120'd0, data_out}, 128'h02);
    checkOutput("irq_lags_clear", {127'd0, irq}, 128'd1);
    applyStimulus(8'hD1, 1'b0, 8'h00);
    checkOutput("w1c_cleared", {120'd0, data_out}, '0);
    checkOutput("irq_dropped", {127'd0, irq}, '0);

    // Read-only and unmapped writes leave state alone
    applyStimulus(8'hF0, 1'b1, 8'h55);
    applyStimulus(8'h10, 1'b1, 8'h77);
    checkOutput("ro_unmapped_port_out", port_out, exp_port_out);
    applyStimulus(8'hF0, 1'b0, 8'h00);
    checkOutput("in0_unchanged", {120'd0, data_out}, 128'hFF);
    applyStimulus(8'h10, 1'b0, 8'h00);
    checkOutput("miss_data", {120'd0, data_out}, '0);
    checkOutput("miss_hit", {127'd0, hit}, '0);
    applyStimulus(8'hD9, 1'b0, 8'h00);
    checkOutput("mask1_read", {120'd0, data_out}, 128'h02);

    // Build up nonzero chg/mask/irq on port 0, then reset mid-sequence
    applyStimulus(8'hD8, 1'b1, 8'h01);
    port_in[0 +: DW] = 8'h01;
    for (int i = 0; i < 4; i++) applyStimulus(8'h10, 1'b0, 8'h00);
    checkOutput("pre_reset_irq", {127'd0, irq}, 128'd1);
    applyStimulus(8'hE3, 1'b0, 8'h00);
    reset = 1'b1;
    applyStimulus(8'hE3, 1'b0, 8'h00);
    exp_port_out = '0;
    checkOutput("mid_reset_port_out", port_out, exp_port_out);
    checkOutput("mid_reset_irq", {127'd0, irq}, '0);
    checkOutput("mid_reset_hit", {127'd0, hit}, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'h10, 1'b0, 8'h00);
    applyStimulus(8'hD0, 1'b0, 8'h00);
    checkOutput("rearm_chg0", {120'd0, data_out}, '0);
    applyStimulus(8'hD1, 1'b0, 8'h00);
    checkOutput("rearm_chg1", {120'd0, data_out}, '0);
    applyStimulus(8'hD8, 1'b0, 8'h00);
    checkOutput("rearm_mask0", {120'd0, data_out}, '0);

    // Detection works again once re-armed
    port_in[2*DW +: DW] = 8'h00;
    for (int i = 0; i < 4; i++) applyStimulus(8'hD0, 1'b0, 8'h00);
    checkOutput("rearm_evt_port2", {120'd0, data_out}, 128'h04);
    checkOutput("rearm_irq_masked", {127'd0, irq}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
